quiz_round_ctrl: RTL

Parametrised successor to the two-player remote answer checker. Synchronises and edge-detects active-low remote buttons for NUM_PLAYERS players × NUM_CHOICES choices and arbitrates the first valid press. Judges each press against the current problem's answer, keeps saturating per-player scores, enforces wrong-answer lockout and a round timeout, and pulses next_prob to advance the problem sequencer.

---
 rtl/quiz_round_ctrl.sv | 210 +++++++++++++++++++++
 1 files changed

// File: rtl/quiz_round_ctrl.sv
// quiz_round_ctrl
// Multi-player quiz round controller. Active-low remote buttons are
// synchronised and edge-detected. The first valid press in a cycle wins
// arbitration and is judged against the latched answer. Per-player scores
// saturate at their maximum. A wrong answer locks that player out for the
// rest of the round, and the round ends on a correct answer, when every
// player is locked out, or on timeout. After a fixed reveal period the
// block pulses next_prob to advance the problem sequencer.
module quiz_round_ctrl #(
  parameter int  NUM_PLAYERS    = 2,
  parameter int  NUM_CHOICES    = 4,
  parameter int  SCORE_W        = 4,
  parameter int  TIMEOUT_CYCLES = 1000,
  parameter int  REVEAL_CYCLES  = 4,
  localparam int CHOICE_W       = $clog2(NUM_CHOICES + 1),
  localparam int PLAYER_W       = $clog2(NUM_PLAYERS + 1)
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            start,
  input  logic                            clr_scores,
  input  logic [CHOICE_W-1:0]             prob,
  input  logic [NUM_PLAYERS*NUM_CHOICES-1:0] rm_in_bcd,
  output logic [NUM_PLAYERS*SCORE_W-1:0]  scores,
  output logic [PLAYER_W-1:0]             winner,
  output logic [NUM_PLAYERS-1:0]          lockout,
  output logic                            busy,
  output logic                            next_prob
);

  localparam int BTN_W     = NUM_PLAYERS * NUM_CHOICES;
  localparam int TIMER_MAX = (TIMEOUT_CYCLES > REVEAL_CYCLES) ? TIMEOUT_CYCLES : REVEAL_CYCLES;
  localparam int TIMER_W   = $clog2(TIMER_MAX + 1);

  localparam logic [TIMER_W-1:0]     TIMEOUT_LAST = TIMER_W'(TIMEOUT_CYCLES - 1);
  localparam logic [TIMER_W-1:0]     REVEAL_LAST  = TIMER_W'(REVEAL_CYCLES - 1);
  localparam logic [SCORE_W-1:0]     SCORE_MAX    = '1;
  localparam logic [NUM_PLAYERS-1:0] ALL_LOCKED   = '1;
  localparam logic [CHOICE_W-1:0]    CHOICE_MAX   = CHOICE_W'(NUM_CHOICES);

  // Round states
  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_ARMED   = 2'd1;
  localparam logic [1:0] S_REVEAL  = 2'd2;
  localparam logic [1:0] S_ADVANCE = 2'd3;

  logic [1:0]                     state;
  logic [BTN_W-1:0]               sync1;
  logic [BTN_W-1:0]               sync2;
  logic [BTN_W-1:0]               prev;
  logic [BTN_W-1:0]               press;
  logic [TIMER_W-1:0]             timer;
  logic [CHOICE_W-1:0]            answer;
  logic [SCORE_W-1:0]             score [NUM_PLAYERS];

  logic                           answer_ok;
  logic [NUM_PLAYERS-1:0]         press_valid;
  logic [NUM_PLAYERS*CHOICE_W-1:0] press_choice;
  logic                           arb_found;
  logic                           arb_correct;
  logic [NUM_PLAYERS-1:0]         arb_onehot;
  logic [PLAYER_W-1:0]            arb_player;
  logic [NUM_PLAYERS-1:0]         lock_next;

  // Two-flop synchroniser plus previous-value register; released buttons read as ones
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1 <= '1;
      sync2 <= '1;
      prev  <= '1;
    end else begin
      sync1 <= rm_in_bcd;
      sync2 <= sync1;
      prev  <= sync2;
    end
  end

  // A falling edge on an active-low button is a new press
  assign press = prev & ~sync2;

  // Per-player decode: a press counts only when exactly one button edge and one button held
  always_comb begin
    int edge_cnt;
    int low_cnt;
    edge_cnt     = 0;
    low_cnt      = 0;
    press_valid  = '0;
    press_choice = '0;
    for (int p = 0; p < NUM_PLAYERS; p++) begin
      edge_cnt = 0;
      low_cnt  = 0;
      for (int c = 1; c <= NUM_CHOICES; c++) begin
        if (!sync2[(NUM_PLAYERS - p) * NUM_CHOICES - c]) begin
          low_cnt = low_cnt + 1;
        end
        if (press[(NUM_PLAYERS - p) * NUM_CHOICES - c]) begin
          edge_cnt = edge_cnt + 1;
          press_choice[p*CHOICE_W +: CHOICE_W] = CHOICE_W'(c);
        end
      end
      press_valid[p] = (edge_cnt == 1) && (low_cnt == 1);
    end
  end

  // An out-of-range latched answer means no press can ever be right
  assign answer_ok = (answer != '0) && (answer <= CHOICE_MAX);

  // Lowest-numbered unlocked player with a valid press wins the cycle
  always_comb begin
    arb_found   = 1'b0;
    arb_correct = 1'b0;
    arb_onehot  = '0;
    arb_player  = '0;
    for (int p = NUM_PLAYERS - 1; p >= 0; p--) begin
      if (press_valid[p] && !lockout[p]) begin
        arb_found     = 1'b1;
        arb_player    = PLAYER_W'(p + 1);
        arb_onehot    = '0;
        arb_onehot[p] = 1'b1;
        arb_correct   = answer_ok && (press_choice[p*CHOICE_W +: CHOICE_W] == answer);
      end
    end
    lock_next = lockout | arb_onehot;
  end

  // Round sequencing: timer, latched answer, winner and lockout
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= S_IDLE;
      timer   <= '0;
      answer  <= '0;
      winner  <= '0;
      lockout <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            answer  <= prob;
            lockout <= '0;
            winner  <= '0;
            timer   <= '0;
            state   <= S_ARMED;
          end
        end
        S_ARMED: begin
          timer <= timer + 1'b1;
          if (arb_found && arb_correct) begin
            winner <= arb_player;
            timer  <= '0;
            state  <= S_REVEAL;
          end else begin
            if (arb_found) begin
              lockout <= lock_next;
            end
            if ((arb_found && (lock_next == ALL_LOCKED)) || (timer == TIMEOUT_LAST)) begin
              winner <= '0;
              timer  <= '0;
              state  <= S_REVEAL;
            end
          end
        end
        S_REVEAL: begin
          if (timer == REVEAL_LAST) begin
            timer <= '0;
            state <= S_ADVANCE;
          end else begin
            timer <= timer + 1'b1;
          end
        end
        S_ADVANCE: begin
          state <= S_IDLE;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

  // Saturating per-player scores; clearing is only accepted between rounds
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int p = 0; p < NUM_PLAYERS; p++) begin
        score[p] <= '0;
      end
    end else if ((state == S_IDLE) && clr_scores) begin
      for (int p = 0; p < NUM_PLAYERS; p++) begin
        score[p] <= '0;
      end
    end else if ((state == S_ARMED) && arb_found && arb_correct) begin
      for (int p = 0; p < NUM_PLAYERS; p++) begin
        if (arb_onehot[p] && (score[p] != SCORE_MAX)) begin
          score[p] <= score[p] + 1'b1;
        end
      end
    end
  end

  // Pack the scores with player 1 in the least significant field
  always_comb begin
    scores = '0;
    for (int p = 0; p < NUM_PLAYERS; p++) begin
      scores[p*SCORE_W +: SCORE_W] = score[p];
    end
  end

  assign busy      = (state != S_IDLE);
  assign next_prob = (state == S_ADVANCE);

endmodule
